lz4_buf_ctrl: RTL and testbench
===============================

# lz4_buf_ctrl

Sequencer and arbiter for the LZ4 history buffer (`lz4_buffer_v2`). It runs each compression block in order: clean, fill, slide the window, then drain. Within a block it shares the buffer's single access slot between the upstream word writer and the match-finder's read port. It sits between the input stream and the buffer, and owns every buffer control strobe.

## Interface
Parameters:
- `SLIDE_BYTES`, default 16'd4096: window slide distance driven on `move_distance`; must be a nonzero multiple of 4.

Ports:
- `clk` in 1: single clock; everything is on the rising edge.
- `rstN` in 1: asynchronous, active-low reset.
- `start` in 1: pulse that begins a block; ignored unless in IDLE.
- `done` out 1: one-cycle pulse when a block completes.
- `in_data` in 32: upstream data word.
- `in_valid` in 1: upstream word is valid.
- `in_last` in 1: marks the final word of the block.
- `in_ready` out 1: word accepted this cycle when `in_valid & in_ready`.
- `rd_req` in 1: match-finder read request; held high until `rd_grant`.
- `rd_addr` in 32: byte address of the read.
- `rd_grant` out 1: one-cycle pulse; request accepted.
- `rd_data` out 32: read result.
- `rd_valid` out 1: one-cycle pulse; `rd_data`/`rd_miss` valid.
- `rd_miss` out 1: address was outside the window; `rd_data`=0.
- `buf_clean` out 1: buffer clear strobe.
- `buf_unable` in 1: buffer busy, e.g. during a clean.
- `compress_end` out 1: end-of-block strobe to the buffer.
- `buf_idword` out 32: write data.
- `buf_idvalid` out 1: write strobe.
- `buf_waddr` out 32: write byte address.
- `buf_full` in 1: buffer full.
- `buf_rdreq` out 1: read strobe.
- `buf_raddr` out 32: read byte address.
- `buf_odata` in 32: buffer read data.
- `buf_ovalid` in 1: buffer read data valid.
- `move_valid` out 1: window slide strobe.
- `move_distance` out 16: slide distance.
- `head_addr` in 32: oldest valid byte address in the window.

## Operation
- Internal state:
  - `wptr`: 32-bit byte write pointer; cleared in CLEAN; +4 per accepted word; modulo-2^32 arithmetic.
  - `rd_busy`: one read is outstanding.
  - `rr`: round-robin flag; 0 means read has priority next.
- States and transitions:
  - IDLE: all strobes low. `start` moves to CLEAN.
  - CLEAN: `buf_clean`=1 for the first cycle only. Stay while `buf_unable`=1. When `buf_unable`=0, go to FILL.
  - FILL: at most one buffer access per cycle.
    - Eligible write: `in_valid & !buf_full`.
    - Eligible read: `rd_req & !rd_busy`.
    - If both are eligible, grant per `rr`, then toggle `rr`. If only one is eligible, grant it and leave `rr` unchanged.
    - Write grant: `in_ready`=1, `buf_idvalid`=1, `buf_idword`=`in_data`, `buf_waddr`=`wptr`.
    - Read grant: `rd_grant`=1.
      - Out of window (`rd_addr - head_addr >= wptr - head_addr`, unsigned): no buffer access; next cycle `rd_valid`=1, `rd_miss`=1.
      - In window: `buf_rdreq`=1, `buf_raddr`=`rd_addr`, `rd_busy`=1.
  - Slide trigger (from FILL): `in_valid & buf_full & (wptr - head_addr >= SLIDE_BYTES)` goes to SLIDE. Otherwise the write stalls with `in_ready`=0.
  - Last word: accepting it with `in_last`=1 goes to DRAIN.
  - SLIDE: `move_valid`=1 and `move_distance`=`SLIDE_BYTES` for one cycle. Next cycle is a settle cycle (no grants), then return to FILL. Reads in flight still complete.
  - DRAIN: no new grants. Wait for `rd_busy`=0, then `compress_end`=1 for one cycle, then DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- Read return: on `buf_ovalid`, register `buf_odata` into `rd_data`, pulse `rd_valid` with `rd_miss`=0, and clear `rd_busy`.
- Pending `rd_req` outside FILL is held off (no grant).

## Timing
- All outputs are registered except `in_ready` and `rd_grant`, which are combinational from the state and the inputs.
- Reset values: all strobes 0, data/address outputs 0, `move_distance`=0, state IDLE, `wptr`=0, `rr`=0, `rd_busy`=0.
- Write latency: the buffer strobes appear the cycle after `in_valid & in_ready`.
- Read latency:
  - In-window: `buf_rdreq` the cycle after grant; `rd_valid` the cycle after `buf_ovalid`.
  - Miss: `rd_valid` exactly 1 cycle after grant.
- Sustained write throughput is 1 word/clk when no reads compete.
- `rstN` low in any state aborts immediately. Any outstanding read is dropped and no `rd_valid` follows.
- A late `buf_ovalid` arriving in IDLE is ignored.

## Test plan
- **Fill:** `start`, `buf_unable` high for 3 cycles, then stream 8 words 0x11110000+i with `in_last` on the last. Expect:
  - one `buf_clean` pulse;
  - `buf_waddr` 0,4,…,28;
  - one `compress_end`, then one `done`.
- **Arbitration:** `in_valid` and `rd_req` held together with `rd_addr`=0 after 4 words are written. Expect:
  - read granted first;
  - grants alternate R,W,R,W.
- **Read miss:** `rd_addr`=0x100 with `wptr`=0x20 and `head_addr`=0. Expect `rd_grant`, then next cycle `rd_valid`=1, `rd_miss`=1, `rd_data`=0, and no `buf_rdreq`.
- **Slide:** `SLIDE_BYTES`=16, `buf_full` asserted at `wptr`=0x40 with `head_addr`=0. Expect:
  - one `move_valid` pulse with `move_distance`=16;
  - one settle cycle;
  - write resumes once `buf_full` drops.
- **Slide refused:** `buf_full` asserted at `wptr`=8 with `SLIDE_BYTES`=16. Expect `in_ready`=0 held and no `move_valid`.
- **Reset mid-read:** `rstN` pulsed low after `buf_rdreq`, with `buf_ovalid` arriving later. Expect all outputs 0, state IDLE, and no `rd_valid`.

Source files
------------

// File: rtl/lz4_buf_ctrl_if.sv
// Bundles every handshake and bus signal around the LZ4 history-buffer
// controller: block start/done, upstream word stream, match-finder read
// port, and the strobes/data exchanged with the history buffer itself.
interface lz4_buf_ctrl_if;
  // block control
  logic        start;
  logic        done;
  // upstream word stream
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  // match-finder read port
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_grant;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_miss;
  // history buffer side
  logic        buf_clean;
  logic        buf_unable;
  logic        compress_end;
  logic [31:0] buf_idword;
  logic        buf_idvalid;
  logic [31:0] buf_waddr;
  logic        buf_full;
  logic        buf_rdreq;
  logic [31:0] buf_raddr;
  logic [31:0] buf_odata;
  logic        buf_ovalid;
  logic        move_valid;
  logic [15:0] move_distance;
  logic [31:0] head_addr;

  // the controller
  modport master (
    input  start, in_data, in_valid, in_last, rd_req, rd_addr,
           buf_unable, buf_full, buf_odata, buf_ovalid, head_addr,
    output done, in_ready, rd_grant, rd_data, rd_valid, rd_miss,
           buf_clean, compress_end, buf_idword, buf_idvalid, buf_waddr,
           buf_rdreq, buf_raddr, move_valid, move_distance
  );

  // everything around the controller (stream source, match finder, buffer)
  modport slave (
    output start, in_data, in_valid, in_last, rd_req, rd_addr,
           buf_unable, buf_full, buf_odata, buf_ovalid, head_addr,
    input  done, in_ready, rd_grant, rd_data, rd_valid, rd_miss,
           buf_clean, compress_end, buf_idword, buf_idvalid, buf_waddr,
           buf_rdreq, buf_raddr, move_valid, move_distance
  );
endinterface

// File: rtl/lz4_buf_ctrl.sv
// Sequencer/arbiter for the LZ4 history buffer. Runs each block through
// clean, fill (with window slides as needed) and drain, and shares the
// buffer's single access slot between the word writer and the match finder.
module lz4_buf_ctrl #(
  parameter logic [15:0] SLIDE_BYTES = 16'd4096
) (
  input logic           clk,
  input logic           rstN,
  lz4_buf_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CLEAN, ST_FILL, ST_SLIDE, ST_SETTLE, ST_DRAIN, ST_END, ST_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] wptr_q, wptr_d;
  logic        rr_q, rr_d;
  logic        rd_busy_q, rd_busy_d;
  logic        done_q, done_d;
  logic        buf_clean_q, buf_clean_d;
  logic        compress_end_q, compress_end_d;
  logic        buf_idvalid_q, buf_idvalid_d;
  logic [31:0] buf_idword_q, buf_idword_d;
  logic [31:0] buf_waddr_q, buf_waddr_d;
  logic        buf_rdreq_q, buf_rdreq_d;
  logic [31:0] buf_raddr_q, buf_raddr_d;
  logic        move_valid_q, move_valid_d;
  logic [15:0] move_distance_q, move_distance_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        rd_miss_q, rd_miss_d;

  logic        grant_wr, grant_rd;
  logic        wr_elig, rd_elig;
  logic [31:0] rd_off, win_len;
  logic        rd_out_of_window, slide_ok;

  assign wr_elig          = bus.in_valid & ~bus.buf_full;
  assign rd_elig          = bus.rd_req & ~rd_busy_q;
  assign rd_off           = bus.rd_addr - bus.head_addr;
  assign win_len          = wptr_q - bus.head_addr;
  assign rd_out_of_window = (rd_off >= win_len);
  assign slide_ok         = bus.in_valid & bus.buf_full & (win_len >= {16'd0, SLIDE_BYTES});

  // Next-state, arbitration and next values of all registered outputs
  always_comb begin
    state_d         = state_q;
    wptr_d          = wptr_q;
    rr_d            = rr_q;
    rd_busy_d       = rd_busy_q;
    done_d          = 1'b0;
    buf_clean_d     = 1'b0;
    compress_end_d  = 1'b0;
    buf_idvalid_d   = 1'b0;
    buf_idword_d    = buf_idword_q;
    buf_waddr_d     = buf_waddr_q;
    buf_rdreq_d     = 1'b0;
    buf_raddr_d     = buf_raddr_q;
    move_valid_d    = 1'b0;
    move_distance_d = 16'd0;
    rd_data_d       = rd_data_q;
    rd_valid_d      = 1'b0;
    rd_miss_d       = 1'b0;
    grant_wr        = 1'b0;
    grant_rd        = 1'b0;

    // a return only counts while a read is outstanding, so stale data after reset is dropped
    if (bus.buf_ovalid && rd_busy_q) begin
      rd_data_d  = bus.buf_odata;
      rd_valid_d = 1'b1;
      rd_busy_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d     = ST_CLEAN;
          buf_clean_d = 1'b1;
        end
      end
      ST_CLEAN: begin
        wptr_d = 32'd0;
        if (!bus.buf_unable) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (wr_elig && rd_elig) begin
          grant_rd = ~rr_q;
          grant_wr = rr_q;
          rr_d     = ~rr_q;
        end else begin
          grant_wr = wr_elig;
          grant_rd = rd_elig;
        end
        if (grant_wr) begin
          buf_idvalid_d = 1'b1;
          buf_idword_d  = bus.in_data;
          buf_waddr_d   = wptr_q;
          wptr_d        = wptr_q + 32'd4;
          if (bus.in_last) state_d = ST_DRAIN;
        end
        if (grant_rd) begin
          if (rd_out_of_window) begin
            rd_valid_d = 1'b1;
            rd_miss_d  = 1'b1;
            rd_data_d  = 32'd0;
          end else begin
            buf_rdreq_d = 1'b1;
            buf_raddr_d = bus.rd_addr;
            rd_busy_d   = 1'b1;
          end
        end
        if (slide_ok) begin
          state_d         = ST_SLIDE;
          move_valid_d    = 1'b1;
          move_distance_d = SLIDE_BYTES;
        end
      end
      ST_SLIDE:  state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_FILL;
      ST_DRAIN: begin
        if (!rd_busy_q) begin
          state_d        = ST_END;
          compress_end_d = 1'b1;
        end
      end
      ST_END: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts whatever is in progress
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q         <= ST_IDLE;
      wptr_q          <= 32'd0;
      rr_q            <= 1'b0;
      rd_busy_q       <= 1'b0;
      done_q          <= 1'b0;
      buf_clean_q     <= 1'b0;
      compress_end_q  <= 1'b0;
      buf_idvalid_q   <= 1'b0;
      buf_idword_q    <= 32'd0;
      buf_waddr_q     <= 32'd0;
      buf_rdreq_q     <= 1'b0;
      buf_raddr_q     <= 32'd0;
      move_valid_q    <= 1'b0;
      move_distance_q <= 16'd0;
      rd_data_q       <= 32'd0;
      rd_valid_q      <= 1'b0;
      rd_miss_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      wptr_q          <= wptr_d;
      rr_q            <= rr_d;
      rd_busy_q       <= rd_busy_d;
      done_q          <= done_d;
      buf_clean_q     <= buf_clean_d;
      compress_end_q  <= compress_end_d;
      buf_idvalid_q   <= buf_idvalid_d;
      buf_idword_q    <= buf_idword_d;
      buf_waddr_q     <= buf_waddr_d;
      buf_rdreq_q     <= buf_rdreq_d;
      buf_raddr_q     <= buf_raddr_d;
      move_valid_q    <= move_valid_d;
      move_distance_q <= move_distance_d;
      rd_data_q       <= rd_data_d;
      rd_valid_q      <= rd_valid_d;
      rd_miss_q       <= rd_miss_d;
    end
  end

  assign bus.in_ready      = grant_wr;
  assign bus.rd_grant      = grant_rd;
  assign bus.done          = done_q;
  assign bus.buf_clean     = buf_clean_q;
  assign bus.compress_end  = compress_end_q;
  assign bus.buf_idvalid   = buf_idvalid_q;
  assign bus.buf_idword    = buf_idword_q;
  assign bus.buf_waddr     = buf_waddr_q;
  assign bus.buf_rdreq     = buf_rdreq_q;
  assign bus.buf_raddr     = buf_raddr_q;
  assign bus.move_valid    = move_valid_q;
  assign bus.move_distance = move_distance_q;
  assign bus.rd_data       = rd_data_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.rd_miss       = rd_miss_q;

endmodule

// File: tb/tb_lz4_buf_ctrl.sv
// Directed bench for lz4_buf_ctrl: fill, arbitration, read miss, slide,
// refused slide and reset during an outstanding read.
module tb_lz4_buf_ctrl;

  logic clk;
  logic rstN;
  int   checks;
  int   errors;

  lz4_buf_ctrl_if bus ();

  lz4_buf_ctrl #(.SLIDE_BYTES(16'd16)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  // free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // streams n consecutive words, one per clock, checking the buffer write strobes
  task automatic applyStimulus(input int n, input logic [31:0] data0,
                               input logic [31:0] addr0, input bit last);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = data0 + 32'(i);
      bus.in_last  = last && (i == n - 1);
      #1;
      checkOutput("in_ready_wr", {31'd0, bus.in_ready}, 32'd1);
      cyc();
      checkOutput("buf_idvalid", {31'd0, bus.buf_idvalid}, 32'd1);
      checkOutput("buf_waddr", bus.buf_waddr, addr0 + 32'(4 * i));
      checkOutput("buf_idword", bus.buf_idword, data0 + 32'(i));
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // end-of-block sequence once the last word has been accepted
  task automatic expectFinish();
    checkOutput("compress_end_early", {31'd0, bus.compress_end}, 32'd0);
    cyc();
    checkOutput("compress_end", {31'd0, bus.compress_end}, 32'd1);
    checkOutput("done_early", {31'd0, bus.done}, 32'd0);
    cyc();
    checkOutput("compress_end_off", {31'd0, bus.compress_end}, 32'd0);
    checkOutput("done", {31'd0, bus.done}, 32'd1);
    cyc();
    checkOutput("done_off", {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstN           = 1'b0;
    bus.start      = 1'b0;
    bus.in_data    = 32'd0;
    bus.in_valid   = 1'b1;
    bus.in_last    = 1'b0;
    bus.rd_req     = 1'b1;
    bus.rd_addr    = 32'd0;
    bus.buf_unable = 1'b0;
    bus.buf_full   = 1'b0;
    bus.buf_odata  = 32'd0;
    bus.buf_ovalid = 1'b0;
    bus.head_addr  = 32'd0;
    #12;
    $display("[TB] reset state");
    checkOutput("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    checkOutput("rst_rd_grant", {31'd0, bus.rd_grant}, 32'd0);
    checkOutput("rst_buf_clean", {31'd0, bus.buf_clean}, 32'd0);
    checkOutput("rst_buf_waddr", bus.buf_waddr, 32'd0);
    checkOutput("rst_move_distance", {16'd0, bus.move_distance}, 32'd0);
    checkOutput("rst_done", {31'd0, bus.done}, 32'd0);
    bus.in_valid = 1'b0;
    bus.rd_req   = 1'b0;
    rstN = 1'b1;
    cyc();

    // ---------------- block 1: plain fill ----------------
    $display("[TB] fill");
    bus.start = 1'b1;
    cyc();
    bus.start      = 1'b0;
    bus.buf_unable = 1'b1;
    checkOutput("buf_clean", {31'd0, bus.buf_clean}, 32'd1);
    cyc();
    checkOutput("buf_clean_once", {31'd0, bus.buf_clean}, 32'd0);
    cyc();
    checkOutput("buf_clean_once2", {31'd0, bus.buf_clean}, 32'd0);
    cyc();
    bus.buf_unable = 1'b0;
    bus.in_valid   = 1'b1;
    #1;
    checkOutput("clean_hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    cyc();
    applyStimulus(8, 32'h1111_0000, 32'd0, 1'b1);
    expectFinish();

    // ---------------- block 2 ----------------
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    checkOutput("buf_clean_b2", {31'd0, bus.buf_clean}, 32'd1);
    cyc();
    applyStimulus(2, 32'h2222_0000, 32'd0, 1'b0);

    $display("[TB] slide refused");
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h2222_AAAA;
    bus.buf_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("refused_in_ready", {31'd0, bus.in_ready}, 32'd0);
      cyc();
      checkOutput("refused_move_valid", {31'd0, bus.move_valid}, 32'd0);
      checkOutput("refused_idvalid", {31'd0, bus.buf_idvalid}, 32'd0);
    end
    bus.buf_full = 1'b0;
    bus.in_valid = 1'b0;
    applyStimulus(2, 32'h2222_0010, 32'd8, 1'b0);

    $display("[TB] arbitration");
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h2222_BBBB;
    bus.rd_req   = 1'b1;
    bus.rd_addr  = 32'd0;
    #1;
    checkOutput("arb1_rd_grant", {31'd0, bus.rd_grant}, 32'd1);
    checkOutput("arb1_in_ready", {31'd0, bus.in_ready}, 32'd0);
    cyc();
    checkOutput("arb1_buf_rdreq", {31'd0, bus.buf_rdreq}, 32'd1);
    checkOutput("arb1_buf_raddr", bus.buf_raddr, 32'd0);
    checkOutput("arb1_idvalid", {31'd0, bus.buf_idvalid}, 32'd0);
    bus.in_valid   = 1'b0;
    bus.rd_req     = 1'b0;
    bus.buf_ovalid = 1'b1;
    bus.buf_odata  = 32'hCAFE_0001;
    cyc();
    checkOutput("ret_rd_valid", {31'd0, bus.rd_valid}, 32'd1);
    checkOutput("ret_rd_data", bus.rd_data, 32'hCAFE_0001);
    checkOutput("ret_rd_miss", {31'd0, bus.rd_miss}, 32'd0);
    bus.buf_ovalid = 1'b0;
    bus.in_valid   = 1'b1;
    bus.rd_req     = 1'b1;
    bus.rd_addr    = 32'h0000_1000;
    #1;
    checkOutput("arb2_in_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("arb2_rd_grant", {31'd0, bus.rd_grant}, 32'd0);
    cyc();
    checkOutput("arb2_waddr", bus.buf_waddr, 32'd16);
    checkOutput("arb2_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    bus.in_data = 32'h2222_CCCC;
    #1;
    checkOutput("arb3_rd_grant", {31'd0, bus.rd_grant}, 32'd1);
    checkOutput("arb3_in_ready", {31'd0, bus.in_ready}, 32'd0);
    cyc();
    checkOutput("arb3_rd_miss", {31'd0, bus.rd_miss}, 32'd1);
    checkOutput("arb3_idvalid", {31'd0, bus.buf_idvalid}, 32'd0);
    #1;
    checkOutput("arb4_in_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("arb4_rd_grant", {31'd0, bus.rd_grant}, 32'd0);
    cyc();
    checkOutput("arb4_waddr", bus.buf_waddr, 32'd20);
    checkOutput("arb4_idword", bus.buf_idword, 32'h2222_CCCC);
    bus.in_valid = 1'b0;
    bus.rd_req   = 1'b0;
    applyStimulus(2, 32'h2222_0020, 32'd24, 1'b0);

    $display("[TB] read miss");
    bus.rd_req  = 1'b1;
    bus.rd_addr = 32'h0000_0100;
    #1;
    checkOutput("miss_rd_grant", {31'd0, bus.rd_grant}, 32'd1);
    cyc();
    checkOutput("miss_rd_valid", {31'd0, bus.rd_valid}, 32'd1);
    checkOutput("miss_rd_miss", {31'd0, bus.rd_miss}, 32'd1);
    checkOutput("miss_rd_data", bus.rd_data, 32'd0);
    checkOutput("miss_buf_rdreq", {31'd0, bus.buf_rdreq}, 32'd0);
    bus.rd_addr = 32'h0000_0020;
    #1;
    checkOutput("edge_rd_grant", {31'd0, bus.rd_grant}, 32'd1);
    cyc();
    bus.rd_req = 1'b0;
    checkOutput("edge_rd_miss", {31'd0, bus.rd_miss}, 32'd1);
    checkOutput("edge_buf_rdreq", {31'd0, bus.buf_rdreq}, 32'd0);
    applyStimulus(8, 32'h3333_0000, 32'd32, 1'b0);

    $display("[TB] slide");
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b1;
    bus.in_data  = 32'h4444_DDDD;
    bus.buf_full = 1'b1;
    #1;
    checkOutput("slide_in_ready", {31'd0, bus.in_ready}, 32'd0);
    cyc();
    checkOutput("slide_move_valid", {31'd0, bus.move_valid}, 32'd1);
    checkOutput("slide_move_distance", {16'd0, bus.move_distance}, 32'd16);
    #1;
    checkOutput("slide_hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    cyc();
    checkOutput("settle_move_valid", {31'd0, bus.move_valid}, 32'd0);
    bus.buf_full  = 1'b0;
    bus.head_addr = 32'd16;
    #1;
    checkOutput("settle_in_ready", {31'd0, bus.in_ready}, 32'd0);
    cyc();
    #1;
    checkOutput("resume_in_ready", {31'd0, bus.in_ready}, 32'd1);
    cyc();
    checkOutput("resume_idvalid", {31'd0, bus.buf_idvalid}, 32'd1);
    checkOutput("resume_waddr", bus.buf_waddr, 32'h40);
    checkOutput("resume_idword", bus.buf_idword, 32'h4444_DDDD);
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.head_addr = 32'd0;
    expectFinish();

    // ---------------- block 3: reset with a read in flight ----------------
    $display("[TB] reset mid-read");
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    cyc();
    applyStimulus(2, 32'h5555_0000, 32'd0, 1'b0);
    bus.rd_req  = 1'b1;
    bus.rd_addr = 32'd4;
    #1;
    checkOutput("mr_rd_grant", {31'd0, bus.rd_grant}, 32'd1);
    cyc();
    bus.rd_req = 1'b0;
    checkOutput("mr_buf_rdreq", {31'd0, bus.buf_rdreq}, 32'd1);
    checkOutput("mr_buf_raddr", bus.buf_raddr, 32'd4);
    rstN = 1'b0;
    #1;
    checkOutput("mr_rst_rdreq", {31'd0, bus.buf_rdreq}, 32'd0);
    checkOutput("mr_rst_raddr", bus.buf_raddr, 32'd0);
    checkOutput("mr_rst_waddr", bus.buf_waddr, 32'd0);
    checkOutput("mr_rst_idword", bus.buf_idword, 32'd0);
    rstN = 1'b1;
    cyc();
    bus.buf_ovalid = 1'b1;
    bus.buf_odata  = 32'h0000_0099;
    bus.rd_req     = 1'b1;
    bus.rd_addr    = 32'd0;
    bus.in_valid   = 1'b1;
    #1;
    checkOutput("idle_rd_grant", {31'd0, bus.rd_grant}, 32'd0);
    checkOutput("idle_in_ready", {31'd0, bus.in_ready}, 32'd0);
    cyc();
    checkOutput("late_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    checkOutput("late_rd_data", bus.rd_data, 32'd0);
    bus.buf_ovalid = 1'b0;
    bus.rd_req     = 1'b0;
    bus.in_valid   = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
